// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point vector multiplier: default lane
// widths, rounding-mode encodings and saturation-limit helpers.
package fxp_pkg;

  // Default lane geometry: A is 12.0, B is 1.31, result is 8.32
  localparam int FXP_NLANE_DEF = 4;
  localparam int FXP_WIIA_DEF  = 12;
  localparam int FXP_WIFA_DEF  = 0;
  localparam int FXP_WIIB_DEF  = 1;
  localparam int FXP_WIFB_DEF  = 31;
  localparam int FXP_WOI_DEF   = 8;
  localparam int FXP_WOF_DEF   = 32;
  localparam int FXP_DEPTH_DEF = 2;

  // Rounding modes
  localparam int FXP_RND_TRUNC   = 0;
  localparam int FXP_RND_HALF_UP = 1;

  // Widest result the limit helpers can produce
  localparam int FXP_MAXW = 256;

  function automatic int fxp_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Largest signed value of width w (0x7F..F), right-aligned
  function automatic logic [FXP_MAXW-1:0] fxp_sat_max(input int w);
    return (FXP_MAXW'(1) << (w - 1)) - FXP_MAXW'(1);
  endfunction

  // Smallest signed value of width w (0x80..0), right-aligned
  function automatic logic [FXP_MAXW-1:0] fxp_sat_min(input int w);
    return FXP_MAXW'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/fxp_mul_lane.sv
// One multiply lane: operand register, full-precision signed product,
// rescale to WOI.WOF with optional half-up rounding, range check and
// (when FXP_MUL_SAT_EN is defined) clamp; then a DEPTH-1 result delay line.
// Every register advances only on en so the whole lane stalls as a unit.
module fxp_mul_lane
  import fxp_pkg::*;
#(
  parameter int WIIA  = FXP_WIIA_DEF,
  parameter int WIFA  = FXP_WIFA_DEF,
  parameter int WIIB  = FXP_WIIB_DEF,
  parameter int WIFB  = FXP_WIFB_DEF,
  parameter int WOI   = FXP_WOI_DEF,
  parameter int WOF   = FXP_WOF_DEF,
  parameter int ROUND = FXP_RND_HALF_UP,
  parameter int DEPTH = FXP_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic [WIIA+WIFA-1:0]   a,
  input  logic [WIIB+WIFB-1:0]   b,
  output logic [WOI+WOF-1:0]     res,
  output logic                   ovf
);

  localparam int WA      = WIIA + WIFA;
  localparam int WB      = WIIB + WIFB;
  localparam int OW      = WOI + WOF;
  localparam int PW      = WA + WB;
  localparam int PF      = WIFA + WIFB;
  // Product fraction is either narrowed (right shift) or padded (left shift)
  localparam int SH_R    = (PF > WOF) ? (PF - WOF) : 0;
  localparam int SH_L    = (WOF > PF) ? (WOF - PF) : 0;
  // Working width: product + left pad + guard bit for the rounding carry,
  // and always at least one bit wider than the output for the range test
  localparam int AW      = PW + 1 + SH_L;
  localparam int XW      = fxp_max(AW, OW) + 1;
  localparam int RND_POS = (SH_R > 0) ? (SH_R - 1) : 0;
  localparam logic signed [XW-1:0] RND_INC =
    (ROUND == FXP_RND_HALF_UP && SH_R > 0) ? (XW'(1) << RND_POS) : XW'(0);

`ifdef FXP_MUL_SAT_EN
  localparam logic [OW-1:0] SAT_MAX = OW'(fxp_sat_max(OW));
  localparam logic [OW-1:0] SAT_MIN = OW'(fxp_sat_min(OW));
`endif

  logic signed [WA-1:0] a_q, a_d;
  logic signed [WB-1:0] b_q, b_d;

  logic signed [PW-1:0] prod;
  logic signed [XW-1:0] ext, ext_l, rnd, aligned;
  logic [XW-OW:0]       hi;
  logic [OW-1:0]        res_c;
  logic                 ovf_c;

  logic [DEPTH-2:0][OW-1:0] res_q, res_d;
  logic [DEPTH-2:0]         ovf_q, ovf_d;

  // Operand capture on pipeline advance
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (en) begin
      a_d = a;
      b_d = b;
    end
  end

  // Operand register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Multiply, align fraction, round half-up (adds half LSB then floors), range check
  always_comb begin
    prod    = PW'(a_q) * PW'(b_q);
    ext     = XW'(prod);
    ext_l   = ext <<< SH_L;
    rnd     = ext_l + RND_INC;
    aligned = rnd >>> SH_R;
    // In range only if every bit above the output sign bit copies it
    hi      = aligned[XW-1:OW-1];
    ovf_c   = ~((&hi) | ~(|hi));
`ifdef FXP_MUL_SAT_EN
    res_c   = ovf_c ? (aligned[XW-1] ? SAT_MIN : SAT_MAX) : aligned[OW-1:0];
`else
    res_c   = aligned[OW-1:0];
`endif
  end

  // Result delay line; entry 0 is the freshly computed value
  always_comb begin
    res_d = res_q;
    ovf_d = ovf_q;
    if (en) begin
      res_d[0] = res_c;
      ovf_d[0] = ovf_c;
      for (int k = 1; k <= DEPTH - 2; k++) begin
        res_d[k] = res_q[k-1];
        ovf_d[k] = ovf_q[k-1];
      end
    end
  end

  // Result registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_q <= '0;
      ovf_q <= '0;
    end else begin
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end

  assign res = res_q[DEPTH-2];
  assign ovf = ovf_q[DEPTH-2];

endmodule

// File: rtl/fxp_mul_vec_pipe.sv
// NLANE-wide fixed-point multiplier with valid/ready flow control.
// The top owns the stage-valid shift register, the single global advance
// (stall) signal, operand-B broadcast and the sticky overflow flag; the
// arithmetic lives in fxp_mul_lane. Build with FXP_MUL_SAT_EN defined to
// clamp overflowing lanes instead of wrapping.
module fxp_mul_vec_pipe
  import fxp_pkg::*;
#(
  parameter int NLANE = FXP_NLANE_DEF,
  parameter int WIIA  = FXP_WIIA_DEF,
  parameter int WIFA  = FXP_WIFA_DEF,
  parameter int WIIB  = FXP_WIIB_DEF,
  parameter int WIFB  = FXP_WIFB_DEF,
  parameter int WOI   = FXP_WOI_DEF,
  parameter int WOF   = FXP_WOF_DEF,
  parameter int ROUND = FXP_RND_HALF_UP,
  parameter int DEPTH = FXP_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           in_vld,
  output logic                           in_rdy,
  input  logic                           bcast,
  input  logic [NLANE*(WIIA+WIFA)-1:0]   ina,
  input  logic [NLANE*(WIIB+WIFB)-1:0]   inb,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic [NLANE*(WOI+WOF)-1:0]     out,
  output logic [NLANE-1:0]               overflow,
  output logic                           ovf_sticky,
  input  logic                           clr_sticky
);

  localparam int WA = WIIA + WIFA;
  localparam int WB = WIIB + WIFB;
  localparam int OW = WOI + WOF;

  logic                       adv;
  logic [DEPTH:1]             vld_pipe_q, vld_pipe_d;
  logic                       ovf_sticky_q, ovf_sticky_d;
  logic [NLANE-1:0][WB-1:0]   b_sel;
  logic [NLANE-1:0][OW-1:0]   res;
  logic [NLANE-1:0]           lane_ovf;

  // Whole pipe moves when the output slot is empty or being drained
  assign out_vld = vld_pipe_q[DEPTH];
  assign adv     = out_rdy | ~out_vld;
  assign in_rdy  = adv;

  // Broadcast replicates lane 0 of B across all lanes
  always_comb begin
    for (int i = 0; i < NLANE; i++)
      b_sel[i] = bcast ? inb[0 +: WB] : inb[i*WB +: WB];
  end

  // Stage-valid shift: bubbles travel as zero bits
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (adv) begin
      vld_pipe_d[1] = in_vld;
      for (int k = 2; k <= DEPTH; k++)
        vld_pipe_d[k] = vld_pipe_q[k-1];
    end
  end

  // Stage-valid register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_pipe_q <= '0;
    else       vld_pipe_q <= vld_pipe_d;
  end

  // Sticky overflow: set on an overflowing transfer, set wins over clear
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (clr_sticky)
      ovf_sticky_d = 1'b0;
    if (out_vld && out_rdy && (|lane_ovf))
      ovf_sticky_d = 1'b1;
  end

  // Sticky overflow register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_sticky_q <= 1'b0;
    else       ovf_sticky_q <= ovf_sticky_d;
  end

  assign ovf_sticky = ovf_sticky_q;

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    fxp_mul_lane #(
      .WIIA  (WIIA),
      .WIFA  (WIFA),
      .WIIB  (WIIB),
      .WIFB  (WIFB),
      .WOI   (WOI),
      .WOF   (WOF),
      .ROUND (ROUND),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .en   (adv),
      .a    (ina[i*WA +: WA]),
      .b    (b_sel[i]),
      .res  (res[i]),
      .ovf  (lane_ovf[i])
    );
  end

  assign out      = res;
  assign overflow = lane_ovf;

endmodule

// File: tb/tb_fxp_mul_vec_pipe.sv
// Directed bench for fxp_mul_vec_pipe at default parameters (4 lanes,
// 12.0 x 1.31 -> 8.32, DEPTH 2). Expected results are hand-computed;
// saturated or wrapped values are chosen by FXP_MUL_SAT_EN.
module tb_fxp_mul_vec_pipe;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_vld, in_rdy, bcast;
  logic [47:0]  ina;
  logic [127:0] inb;
  logic         out_vld, out_rdy;
  logic [159:0] dout;
  logic [3:0]   overflow;
  logic         ovf_sticky, clr_sticky;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [39:0] HALF    = 40'h00_8000_0000;
  localparam logic [39:0] ONE     = 40'h01_0000_0000;
  localparam logic [39:0] ONEHALF = 40'h01_8000_0000;
  localparam logic [39:0] TWO     = 40'h02_0000_0000;
  localparam logic [39:0] TWOHALF = 40'h02_8000_0000;
  localparam logic [39:0] P127H   = 40'h7F_8000_0000;
  localparam logic [39:0] NEG128  = 40'h80_0000_0000;
`ifdef FXP_MUL_SAT_EN
  localparam logic [39:0] E41     = 40'h7F_FFFF_FFFF;
  localparam logic [39:0] E42_0   = 40'h7F_FFFF_FFFF;
  localparam logic [39:0] E42_1   = 40'h80_0000_0000;
`else
  localparam logic [39:0] E41     = 40'hFE_FFFF_F002;
  localparam logic [39:0] E42_0   = 40'h00_0000_0000;
  localparam logic [39:0] E42_1   = 40'h6A_0000_0000;
`endif

  fxp_mul_vec_pipe dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .bcast      (bcast),
    .ina        (ina),
    .inb        (inb),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out        (dout),
    .overflow   (overflow),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] pk(input logic [39:0] o0, o1, o2, o3);
    return {o3, o2, o1, o0};
  endfunction

  task automatic beat(input logic [11:0] a0, a1, a2, a3,
                      input logic [31:0] b0, b1, b2, b3, input logic bc);
    ina    = {a3, a2, a1, a0};
    inb    = {b3, b2, b1, b0};
    bcast  = bc;
    in_vld = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; in_vld = 1'b0; bcast = 1'b0; ina = '0; inb = '0;
    out_rdy = 1'b1; clr_sticky = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out", dout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_in_rdy", in_rdy, 1);
    rstn = 1'b1;
    @(negedge clk);

    // 3 * 0.5 = 1.5, two cycles after accept
    beat(12'd3, 0, 0, 0, 32'h4000_0000, 0, 0, 0, 1'b0);
    chk("lat_in_rdy", in_rdy, 1);
    @(negedge clk); in_vld = 1'b0;
    chk("lat_t1_vld", out_vld, 0);
    @(negedge clk);
    chk("lat_t2_vld", out_vld, 1);
    chk("lat_out", dout, pk(ONEHALF, 0, 0, 0));
    chk("lat_ovf", overflow, 0);
    @(negedge clk);
    chk("lat_drain", out_vld, 0);

    // 2047 * ~1.0 overflows; sticky sets on transfer, then clears
    beat(12'd2047, 0, 0, 0, 32'h7FFF_FFFF, 0, 0, 0, 1'b0);
    @(negedge clk); in_vld = 1'b0;
    @(negedge clk);
    chk("big_out", dout, pk(E41, 0, 0, 0));
    chk("big_ovf", overflow, 4'b0001);
    chk("big_sticky_pre", ovf_sticky, 0);
    @(negedge clk);
    chk("big_sticky_set", ovf_sticky, 1);
    clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    chk("sticky_clr", ovf_sticky, 0);

    // -2048*-1 and -300*0.5 overflow; 255*0.5 and -256*0.5 are in-range edges
    beat(12'h800, 12'hED4, 12'h0FF, 12'hF00,
         32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);
    @(negedge clk); in_vld = 1'b0;
    @(negedge clk);
    chk("edge_out", dout, pk(E42_0, E42_1, P127H, NEG128));
    chk("edge_ovf", overflow, 4'b0011);
    clr_sticky = 1'b1;   // coincides with an overflowing transfer
    @(negedge clk); clr_sticky = 1'b0;
    chk("sticky_set_wins", ovf_sticky, 1);

    // Broadcast: lane 0 of B for all lanes, other B lanes are junk
    beat(12'd1, 12'd2, 12'd3, 12'd4,
         32'h4000_0000, 32'h7FFF_FFFF, 32'h1234_5678, 32'h8000_0000, 1'b1);
    @(negedge clk); in_vld = 1'b0; bcast = 1'b0;
    @(negedge clk);
    chk("bcast_out", dout, pk(HALF, ONE, ONEHALF, TWO));
    chk("bcast_ovf", overflow, 0);
    @(negedge clk);

    // Three back-to-back beats, then a 5-cycle stall
    beat(12'd1, 0, 0, 0, 32'h4000_0000, 0, 0, 0, 1'b0);
    @(negedge clk);
    chk("bb_t1_vld", out_vld, 0);
    beat(12'd2, 0, 0, 0, 32'h4000_0000, 0, 0, 0, 1'b0);
    @(negedge clk);
    chk("bb_a", dout, pk(HALF, 0, 0, 0));
    beat(12'd3, 0, 0, 0, 32'h4000_0000, 0, 0, 0, 1'b0);
    @(negedge clk);
    in_vld = 1'b0; out_rdy = 1'b0;
    chk("bb_b", dout, pk(ONE, 0, 0, 0));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_in_rdy", in_rdy, 0);
      chk("stall_vld", out_vld, 1);
      chk("stall_hold", dout, pk(ONE, 0, 0, 0));
    end
    out_rdy = 1'b1;
    @(negedge clk);
    chk("rel_c_vld", out_vld, 1);
    chk("rel_c", dout, pk(ONEHALF, 0, 0, 0));
    @(negedge clk);
    chk("rel_empty", out_vld, 0);

    // Reset with two beats in flight (sticky is still set from above)
    chk("pre_rst_sticky", ovf_sticky, 1);
    beat(12'd2047, 0, 0, 0, 32'h7FFF_FFFF, 0, 0, 0, 1'b0);
    @(negedge clk);
    beat(12'd3, 0, 0, 0, 32'h4000_0000, 0, 0, 0, 1'b0);
    @(negedge clk);
    in_vld = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_sticky", ovf_sticky, 0);
    chk("mid_rst_out", dout, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(negedge clk); rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_stale", out_vld, 0);
    end
    beat(12'd5, 0, 0, 0, 32'h4000_0000, 0, 0, 0, 1'b0);
    @(negedge clk); in_vld = 1'b0;
    @(negedge clk);
    chk("post_rst_vld", out_vld, 1);
    chk("post_rst_out", dout, pk(TWOHALF, 0, 0, 0));
    chk("post_rst_sticky", ovf_sticky, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
